// File: rtl/sigma_delta_modulator_if.sv
// sigma_delta_modulator_if: bundles the PCM-side and bitstream-side signals of the modulator.
// Ports: osr_i (ratio select), sample_i (signed PCM), sample_rd_o (read strobe), ds_o (bitstream).
// master = sample source / output driver side, slave = modulator side.
interface sigma_delta_modulator_if;
  logic [1:0]         osr_i;
  logic signed [15:0] sample_i;
  logic               sample_rd_o;
  logic               ds_o;

  modport master (
    output osr_i,
    output sample_i,
    input  sample_rd_o,
    input  ds_o
  );

  modport slave (
    input  osr_i,
    input  sample_i,
    output sample_rd_o,
    output ds_o
  );
endinterface

// File: rtl/sigma_delta_modulator.sv
// sigma_delta_modulator: second-order 1-bit sigma-delta modulator, one PCM sample pulled per OSR frame.
// Latency: a sample captured on strobe edge E reaches i1 and ds_o at edge E+1; ds_o is a flop output.
// Backpressure: none; the source must hold sample_i during the sample_rd_o cycle.
// Ports: clk_i, rst_n_i (synchronous, active-low), sdm (slave modport: osr_i, sample_i in;
//        sample_rd_o, ds_o out). Optional macro SDM_DITHER_EN adds +/-1 LFSR dither to integrator 2.
module sigma_delta_modulator #(
  parameter int ACC_W = 20
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  sigma_delta_modulator_if.slave sdm
);

  // Sums carry two guard bits so they can be clamped instead of wrapping.
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX;
  localparam logic signed [SW-1:0] FB_MAG  = {{(SW-16){1'b0}}, 1'b1, 15'd0};

  logic [7:0]                cnt;
  logic [1:0]                osr_q;
  logic [7:0]                last;
  logic                      wrap;
  logic signed [15:0]        hold;
  logic signed [ACC_W-1:0]   i1;
  logic signed [ACC_W-1:0]   i2;
  logic                      ds_q;
  logic                      rd_q;

  logic signed [SW-1:0]      x_ext;
  logic signed [SW-1:0]      fb;
  logic signed [SW-1:0]      dith;
  logic signed [SW-1:0]      i1_sum;
  logic signed [SW-1:0]      i2_sum;
  logic signed [ACC_W-1:0]   i1n;
  logic signed [ACC_W-1:0]   i2n;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_MAX) begin
      sat = SAT_MAX[ACC_W-1:0];
    end else if (v < SAT_MIN) begin
      sat = SAT_MIN[ACC_W-1:0];
    end else begin
      sat = v[ACC_W-1:0];
    end
  endfunction

  // Last count of the frame for the latched ratio.
  always_comb begin
    case (osr_q)
      2'd0:    last = 8'd31;
      2'd1:    last = 8'd63;
      2'd2:    last = 8'd127;
      default: last = 8'd255;
    endcase
  end

  assign wrap = (cnt == last);

`ifdef SDM_DITHER_EN
  localparam logic signed [SW-1:0] ONE = {{(SW-1){1'b0}}, 1'b1};

  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Right-shifting Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign dith    = lfsr[0] ? ONE : -ONE;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end
`else
  assign dith = '0;
`endif

  always_comb begin
    x_ext  = {{(SW-16){hold[15]}}, hold};
    fb     = ds_q ? FB_MAG : -FB_MAG;
    i1_sum = {{2{i1[ACC_W-1]}}, i1} + x_ext - fb;
    i1n    = sat(i1_sum);
    i2_sum = {{2{i2[ACC_W-1]}}, i2} + {{2{i1n[ACC_W-1]}}, i1n} - fb + dith;
    i2n    = sat(i2_sum);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt   <= '0;
      osr_q <= sdm.osr_i;
      hold  <= '0;
      i1    <= '0;
      i2    <= '0;
      ds_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      if (wrap) begin
        cnt   <= '0;
        osr_q <= sdm.osr_i;
        hold  <= sdm.sample_i;
      end else begin
        cnt   <= cnt + 8'd1;
      end
      // Strobe flop tracks "next count is the last one"; after a wrap the
      // count is 0, which is never the last count of any ratio.
      rd_q <= !wrap && ((cnt + 8'd1) == last);
      i1   <= i1n;
      i2   <= i2n;
      ds_q <= ~i2n[ACC_W-1];
    end
  end

  assign sdm.sample_rd_o = rd_q;
  assign sdm.ds_o        = ds_q;

endmodule

// File: tb/tb_sigma_delta_modulator.sv
// tb_sigma_delta_modulator: scoreboard bench for the sigma-delta modulator.
// A frame/integrator model predicts {sample_rd_o, ds_o} after every edge; a negedge monitor compares.
// Directed scenarios add strobe-position and ones-density checks.
module tb_sigma_delta_modulator;
  localparam int ACC_W = 20;

  logic clk;
  logic rst_n;
  sigma_delta_modulator_if bus();

  sigma_delta_modulator #(.ACC_W(ACC_W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .sdm     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  // Reference model state: position in frame, frame length, held sample, integrators.
  int m_phase, m_period, m_hold, m_i1, m_i2, m_ds, m_lfsr;

  function automatic int msat(input int v);
    int lim;
    lim = (1 << (ACC_W - 1)) - 1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic void model_edge(output logic rd, output logic ds);
    int fb, d, bitv;
    int taps[4];
    taps = '{16, 14, 13, 11};
    if (!rst_n) begin
      m_phase  = 0;
      m_period = 32 << int'(bus.osr_i);
      m_hold   = 0;
      m_i1     = 0;
      m_i2     = 0;
      m_ds     = 0;
      m_lfsr   = 16'hACE1;
    end else begin
      fb = (m_ds != 0) ? 32768 : -32768;
      d  = 0;
`ifdef SDM_DITHER_EN
      d = ((m_lfsr & 1) != 0) ? 1 : -1;
      bitv = 0;
      foreach (taps[t]) bitv ^= (m_lfsr >> (16 - taps[t])) & 1;
      m_lfsr = (m_lfsr >> 1) | (bitv << 15);
`else
      bitv = 0;
`endif
      m_i1 = msat(m_i1 + m_hold - fb);
      m_i2 = msat(m_i2 + m_i1 - fb + d);
      m_ds = (m_i2 >= 0) ? 1 : 0;
      if (m_phase == m_period - 1) begin
        m_hold   = int'(bus.sample_i);
        m_phase  = 0;
        m_period = 32 << int'(bus.osr_i);
      end else begin
        m_phase++;
      end
    end
    rd = (m_phase == m_period - 1);
    ds = (m_ds != 0);
  endfunction

  // One clock: predict, let the edge happen, queue the prediction for the monitor.
  task automatic step();
    logic rd, ds;
    model_edge(rd, ds);
    @(posedge clk);
    exp_q.push_back({rd, ds});
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({bus.sample_rd_o, bus.ds_o} !== e) begin
        errors++;
        $display("FAIL stream t=%0t got rd=%b ds=%b expected rd=%b ds=%b",
                 $time, bus.sample_rd_o, bus.ds_o, e[1], e[0]);
      end
    end
  end

  task automatic check_int(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  // Cycle 1 is the first cycle with rst_n high; records strobe cycles and ds of cycles 1..4.
  task automatic collect(input int n, input int sw_cyc, input logic [1:0] sw_osr,
                         output int s0, output int s1, output int s2, output logic [3:0] first_ds);
    int ns;
    ns = 0; s0 = -1; s1 = -1; s2 = -1; first_ds = '0;
    for (int k = 1; k <= n; k++) begin
      if (k <= 4) first_ds[k-1] = bus.ds_o;
      if (bus.sample_rd_o) begin
        case (ns)
          0: s0 = k;
          1: s1 = k;
          2: s2 = k;
          default: ;
        endcase
        ns++;
      end
      if (k == sw_cyc) bus.osr_i = sw_osr;
      step();
    end
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int k = 0; k < n; k++) begin
      ones += int'(bus.ds_o);
      step();
    end
  endtask

  task automatic density(input string name, input logic [1:0] osr, input logic [15:0] smp,
                         input int settle, input int lo, input int hi);
    int ones;
    bus.osr_i    = osr;
    bus.sample_i = smp;
    do_reset(3);
    repeat (settle) step();
    count_ones(256, ones);
    check_int(name, ones, lo, hi);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0, s1, s2, ones;
    logic [3:0] fd;
    logic [3:0] sh;
    int r;

    rst_n        = 1'b0;
    bus.osr_i    = 2'd0;
    bus.sample_i = '0;

    // Reset then strobe period at OSR 32.
    do_reset(3);
    collect(100, 0, 2'd0, s0, s1, s2, fd);
    check_int("strobe1_osr32", s0, 32, 32);
    check_int("strobe2_osr32", s1, 64, 64);
    check_int("strobe3_osr32", s2, 96, 96);

    // Zero input at OSR 64: first bits then density.
    bus.osr_i    = 2'd1;
    bus.sample_i = 16'h0000;
    do_reset(3);
    collect(4, 0, 2'd1, s0, s1, s2, fd);
    check_int("zero_first_bits", int'(fd), 4'b0110, 4'b0110);
    repeat (60) step();
    count_ones(256, ones);
    check_int("zero_density", ones, 126, 130);

    density("neg_quarter_density", 2'd1, 16'hC000, 512, 61, 67);
    density("pos_quarter_density", 2'd1, 16'h4000, 512, 189, 195);
    density("pos_full_density", 2'd1, 16'h7FFF, 4096, 250, 256);
    density("neg_full_density", 2'd1, 16'h8000, 1024, 0, 6);

    // OSR change mid-frame takes effect only at the next wrap.
    bus.osr_i    = 2'd0;
    bus.sample_i = 16'h1234;
    do_reset(3);
    collect(300, 11, 2'd3, s0, s1, s2, fd);
    check_int("osr_change_strobe1", s0, 32, 32);
    check_int("osr_change_strobe2", s1, 288, 288);

    // Reset in the middle of the second frame with hold = 0x4000.
    bus.osr_i    = 2'd0;
    bus.sample_i = 16'h4000;
    do_reset(3);
    repeat (52) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    collect(40, 0, 2'd0, s0, s1, s2, fd);
    check_int("midreset_strobe", s0, 32, 32);
    check_int("midreset_first_bits", int'(fd), 4'b0110, 4'b0110);

    // Randomized traffic: random samples and amplitude, OSR changes, short resets.
    sh = 4'd0;
    repeat (16000) begin
      r = int'($urandom_range(0, 999));
      rst_n = (r >= 2);
      if (r >= 2 && r < 8) bus.osr_i = 2'($urandom_range(0, 3));
      if (r >= 8 && r < 12) sh = 4'($urandom_range(0, 4));
      bus.sample_i = $signed(16'($urandom)) >>> sh;
      step();
    end
    rst_n = 1'b1;
    repeat (4) step();
    @(negedge clk);
    #1;
    check_int("queue_drain", exp_q.size(), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
